// File: rtl/cdc_pulse_scheduler_pkg.sv
// cdc_sched_pkg: shared FSM state type, default parameters and width helpers for pulse-channel schedulers
//   No ports. Provides state_t, DEF_* parameter defaults, idx_w() and cnt_w().
package cdc_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FIRE,
        S_WAIT,
        S_GAP,
        S_DRAIN
    } state_t;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_TIMEOUT = 64;
    localparam int DEF_MIN_GAP = 2;

    // Width of a requester index; a single requester still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Counter wide enough to hold the larger of the two wait lengths without wrapping.
    function automatic int cnt_w(input int timeout, input int min_gap);
        return $clog2(((timeout > min_gap) ? timeout : min_gap) + 1);
    endfunction

endpackage

// File: rtl/cdc_pulse_scheduler_if.sv
// cdc_pulse_scheduler_if: requester/channel signal bundle of the pulse scheduler
//   req[NUM_REQ]   level requests            ack_in        channel ack pulse
//   pulse_out      pulse into the channel    done/err      one-hot completion pulses
//   cur_id         current/last grant        busy          scheduler not idle
//   spurious_ack   ack seen outside WAIT/DRAIN
//   master: the scheduler side; slave: the requesters/channel side.
interface cdc_pulse_scheduler_if #(
    parameter int NUM_REQ = cdc_sched_pkg::DEF_NUM_REQ
) ();
    import cdc_sched_pkg::*;

    localparam int IW = idx_w(NUM_REQ);

    logic [NUM_REQ-1:0] req;
    logic               pulse_out;
    logic               ack_in;
    logic [NUM_REQ-1:0] done;
    logic [NUM_REQ-1:0] err;
    logic [IW-1:0]      cur_id;
    logic               busy;
    logic               spurious_ack;

    modport master (
        input  req, ack_in,
        output pulse_out, done, err, cur_id, busy, spurious_ack
    );

    modport slave (
        output req, ack_in,
        input  pulse_out, done, err, cur_id, busy, spurious_ack
    );

endinterface

// File: rtl/cdc_pulse_scheduler_rr_pick.sv
// rr_pick: combinational round-robin picker, first set req bit searching upward from ptr+1 with wrap
//   req[N]   request vector      ptr    last granted index
//   valid    any request set     idx    chosen index (0 when none)
module rr_pick #(
    parameter int N  = cdc_sched_pkg::DEF_NUM_REQ,
    parameter int IW = cdc_sched_pkg::idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] idx
);
    import cdc_sched_pkg::*;

    // Walk candidates from farthest to nearest so the nearest set bit after ptr is the last writer.
    always_comb begin
        logic [IW-1:0] j;
        valid = |req;
        idx   = '0;
        j     = '0;
        for (int i = N; i >= 1; i--) begin
            j = IW'((int'(ptr) + i >= N) ? int'(ptr) + i - N : int'(ptr) + i);
            if (req[j]) idx = j;
        end
    end

endmodule

// File: rtl/cdc_pulse_scheduler.sv
// cdc_pulse_scheduler: round-robin source sequencer keeping one pulse in flight on a fast-to-slow pulse channel
//   clk, rst (async, active-high) plain ports; bus (master modport) carries req, ack_in,
//   pulse_out, done, err, cur_id, busy, spurious_ack. All outputs are registered.
module cdc_pulse_scheduler #(
    parameter int NUM_REQ = cdc_sched_pkg::DEF_NUM_REQ,
    parameter int TIMEOUT = cdc_sched_pkg::DEF_TIMEOUT,
    parameter int MIN_GAP = cdc_sched_pkg::DEF_MIN_GAP
) (
    input logic                   clk,
    input logic                   rst,
    cdc_pulse_scheduler_if.master bus
);
    import cdc_sched_pkg::*;

    localparam int IW = idx_w(NUM_REQ);
    localparam int CW = cnt_w(TIMEOUT, MIN_GAP);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(MIN_GAP - 1);

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic [IW-1:0]      ptr, pick_idx;
    logic               pick_valid;
    logic [NUM_REQ-1:0] oh;

    rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
        .req   (bus.req),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign oh = NUM_REQ'(1) << bus.cur_id;

    // cnt is cleared on every state exit so each timed state starts counting from zero.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: state_nxt = pick_valid ? S_FIRE : S_IDLE;
            S_FIRE: begin
                state_nxt = S_WAIT;
                cnt_nxt   = '0;
            end
            S_WAIT: begin
                state_nxt = bus.ack_in ? S_GAP : (cnt == TO_LAST) ? S_DRAIN : S_WAIT;
                cnt_nxt   = (bus.ack_in || cnt == TO_LAST) ? '0 : cnt + 1'b1;
            end
            S_GAP: begin
                state_nxt = (cnt == GAP_LAST) ? S_IDLE : S_GAP;
                cnt_nxt   = (cnt == GAP_LAST) ? '0 : cnt + 1'b1;
            end
            S_DRAIN: begin
                state_nxt = (cnt == TO_LAST) ? S_IDLE : S_DRAIN;
                cnt_nxt   = (cnt == TO_LAST) ? '0 : cnt + 1'b1;
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // done/err fire on the first GAP/DRAIN cycle, one clock after the deciding WAIT edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= S_IDLE;
            cnt              <= '0;
            ptr              <= IW'(NUM_REQ - 1);
            bus.cur_id       <= '0;
            bus.pulse_out    <= 1'b0;
            bus.done         <= '0;
            bus.err          <= '0;
            bus.busy         <= 1'b0;
            bus.spurious_ack <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == S_IDLE && pick_valid) begin
                ptr        <= pick_idx;
                bus.cur_id <= pick_idx;
            end
            bus.pulse_out    <= state == S_FIRE;
            bus.done         <= (state == S_GAP && cnt == '0) ? oh : '0;
            bus.err          <= (state == S_DRAIN && cnt == '0) ? oh : '0;
            bus.busy         <= state_nxt != S_IDLE;
            bus.spurious_ack <= bus.ack_in && state != S_WAIT && state != S_DRAIN;
        end
    end

endmodule
